// File: rtl/toy_bus_pkg.sv
// Shared ToyBusAck field widths, payload struct and initiator ids used by the
// ITCM request arbiter and this response demux.
package toy_bus_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned OPCODE_W = 1;

  localparam logic [ID_W-1:0] ID_CORE_IF = 4'd0;
  localparam logic [ID_W-1:0] ID_DMA     = 4'd1;

  // One response beat; packed so it can travel through a plain-width FIFO.
  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [OPCODE_W-1:0] opcode;
    logic [ID_W-1:0]     src_id;
    logic [ID_W-1:0]     tgt_id;
  } ack_t;

  localparam int unsigned ACK_W = $bits(ack_t);

endpackage

// File: rtl/toy_bus_cmn_fifo2.sv
// Two-entry flop FIFO with 1-bit wrapping pointers and a 2-bit occupancy count.
// Storage resets to zero so the read port shows a zero payload out of reset.
module toy_bus_cmn_fifo2 #(
  parameter int unsigned W     = 41,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full     = (cnt_q == 2'(DEPTH));
  assign empty    = (cnt_q == 2'd0);
  assign cnt      = cnt_q;
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO or a pop from an empty one is dropped here as a
  // last line of defence; the parent is expected never to issue either.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and count; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_cnt_range:    assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 2'(DEPTH));

endmodule

// File: rtl/toy_bus_dmux_node_rsp_itcm.sv
// ITCM response demux: routes each ToyBusAck beat to out0/out1 by tgt_id via a
// 2-entry buffer per output; unmatched beats are swallowed and counted.
module toy_bus_dmux_node_rsp_itcm
  import toy_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] OUT0_ID = ID_CORE_IF,
  parameter logic [ID_W-1:0] OUT1_ID = ID_DMA,
  parameter int unsigned     DEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in0_vld,
  output logic                in0_rdy,
  input  logic [DATA_W-1:0]   in0_data,
  input  logic [OPCODE_W-1:0] in0_opcode,
  input  logic [ID_W-1:0]     in0_src_id,
  input  logic [ID_W-1:0]     in0_tgt_id,
  output logic                out0_vld,
  input  logic                out0_rdy,
  output logic [DATA_W-1:0]   out0_data,
  output logic [OPCODE_W-1:0] out0_opcode,
  output logic [ID_W-1:0]     out0_src_id,
  output logic [ID_W-1:0]     out0_tgt_id,
  output logic                out1_vld,
  input  logic                out1_rdy,
  output logic [DATA_W-1:0]   out1_data,
  output logic [OPCODE_W-1:0] out1_opcode,
  output logic [ID_W-1:0]     out1_src_id,
  output logic [ID_W-1:0]     out1_tgt_id,
  output logic                err_vld,
  output logic [7:0]          err_cnt
);

  logic hit0, hit1, miss;
  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;
  logic [1:0] cnt0, cnt1;
  ack_t in_ack, q0, q1;

  // Decode and ready: ready depends only on tgt_id and registered fullness.
  always_comb begin
    hit0    = (in0_tgt_id == OUT0_ID);
    hit1    = (in0_tgt_id == OUT1_ID);
    miss    = !hit0 && !hit1;
    in0_rdy = (hit0 && !full0) || (hit1 && !full1) || miss;
    push0   = in0_vld && in0_rdy && hit0;
    push1   = in0_vld && in0_rdy && hit1;
    pop0    = out0_vld && out0_rdy;
    pop1    = out1_vld && out1_rdy;
    in_ack  = '{data: in0_data, opcode: in0_opcode, src_id: in0_src_id, tgt_id: in0_tgt_id};
  end

  toy_bus_cmn_fifo2 #(.W(ACK_W), .DEPTH(DEPTH)) u_buf0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push0),
    .push_data(in_ack),
    .pop      (pop0),
    .pop_data (q0),
    .full     (full0),
    .empty    (empty0),
    .cnt      (cnt0)
  );

  toy_bus_cmn_fifo2 #(.W(ACK_W), .DEPTH(DEPTH)) u_buf1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push1),
    .push_data(in_ack),
    .pop      (pop1),
    .pop_data (q1),
    .full     (full1),
    .empty    (empty1),
    .cnt      (cnt1)
  );

  // Output unpacking: valid whenever the buffer holds a beat.
  always_comb begin
    out0_vld    = !empty0;
    out0_data   = q0.data;
    out0_opcode = q0.opcode;
    out0_src_id = q0.src_id;
    out0_tgt_id = q0.tgt_id;
    out1_vld    = !empty1;
    out1_data   = q1.data;
    out1_opcode = q1.opcode;
    out1_src_id = q1.src_id;
    out1_tgt_id = q1.tgt_id;
  end

  // Dropped-beat pulse and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_vld <= in0_vld && miss;
      if (in0_vld && miss && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  a_ids_distinct: assert property (@(posedge clk) OUT0_ID != OUT1_ID);
  a_cnt0_ok:      assert property (@(posedge clk) disable iff (!rst_n) cnt0 <= 2'(DEPTH));
  a_cnt1_ok:      assert property (@(posedge clk) disable iff (!rst_n) cnt1 <= 2'(DEPTH));

endmodule
